// File: rtl/fetch_queue.sv
// Instruction fetch stage: drives a synchronous ROM one read per cycle and
// buffers returned words in a small FIFO offered to the decoder.
module fetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               jmp_ce,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 2);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0]  mem_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   credit;
    logic               pop;
    logic               push;

    // Decoder handshake: an entry transfers in any cycle where id_valid and
    // id_ready are both high; id_valid never depends on id_ready, and the
    // offered id_instr/id_pc hold steady until popped or flushed.
    assign id_valid = (count != '0);
    assign pop      = id_valid & id_ready;
    assign push     = inflight & ~jmp_ce;
    assign id_instr = mem_instr[rd_ptr];
    assign id_pc    = mem_pc[rd_ptr];

    // Occupancy after this cycle if the in-flight word lands; a new request
    // is only issued when it is guaranteed a free slot.
    assign credit   = count + CNT_W'(inflight) - CNT_W'(pop);
    assign rom_en   = rst_n & ~jmp_ce & (credit < CNT_W'(DEPTH));
    assign rom_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                inflight_pc <= fetch_pc;
            end
            if (jmp_ce) begin
                // Redirect discards queued words and the pending ROM response.
                fetch_pc <= jmp_addr;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (rom_en) begin
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                end
                if (push) begin
                    mem_instr[wr_ptr] <= rom_data;
                    mem_pc[wr_ptr]    <= inflight_pc;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirects,
// address wrap and mid-operation reset, with a ROM model holding i+0x100.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        jmp_ce;
    logic [7:0]  jmp_addr;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    fetch_queue #(.ADDR_W(8), .INSTR_W(16), .DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .jmp_ce   (jmp_ce),
        .jmp_addr (jmp_addr),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_instr (id_instr),
        .id_pc    (id_pc)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word i holds i+0x100, returned the cycle after the request.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 16'h0100 + {8'h00, rom_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        jmp_ce   = 1'b0;
        jmp_addr = '0;
        id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid", 32'(id_valid), 0);
        chk("rst_rom_en",   32'(rom_en),   0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_id_pc",    32'(id_pc),    0);
        chk("rst_id_instr", 32'(id_instr), 0);

        // Streaming from reset with id_ready held high.
        rst_n = 1'b1;
        #1;
        chk("c0_rom_en",   32'(rom_en),   1);
        chk("c0_rom_addr", 32'(rom_addr), 0);
        chk("c0_id_valid", 32'(id_valid), 0);
        tick();
        chk("c1_rom_addr", 32'(rom_addr), 1);
        chk("c1_id_valid", 32'(id_valid), 0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk("stream_valid", 32'(id_valid), 1);
            chk("stream_pc",    32'(id_pc),    32'(c - 2));
            chk("stream_instr", 32'(id_instr), 32'(16'h0100 + 16'(c - 2)));
        end

        // Jump to 0x40 while pc 5 is offered.
        tick();
        jmp_ce   = 1'b1;
        jmp_addr = 8'h40;
        #1;
        chk("j_pc5_offered", 32'(id_pc),    5);
        chk("j_pc5_valid",   32'(id_valid), 1);
        chk("j_no_request",  32'(rom_en),   0);
        tick();
        jmp_ce = 1'b0;
        #1;
        chk("j1_id_valid", 32'(id_valid), 0);
        chk("j1_rom_en",   32'(rom_en),   1);
        chk("j1_rom_addr", 32'(rom_addr), 32'h40);
        tick();
        chk("j2_id_valid", 32'(id_valid), 0);
        tick();
        chk("j3_id_valid", 32'(id_valid), 1);
        chk("j3_id_pc",    32'(id_pc),    32'h40);
        chk("j3_id_instr", 32'(id_instr), 32'h140);
        tick();
        chk("j4_id_pc", 32'(id_pc), 32'h41);
        tick();
        chk("j5_id_pc", 32'(id_pc), 32'h42);

        // Jump near the top of the address space: wrap 0xFF -> 0x00.
        tick();
        jmp_ce   = 1'b1;
        jmp_addr = 8'hFE;
        tick();
        jmp_ce = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wrap_valid", 32'(id_valid), 1);
            chk("wrap_pc",    32'(id_pc),    32'((8'hFE + 8'(k)) & 8'hFF));
            chk("wrap_instr", 32'(id_instr), 32'(16'h0100 + {8'h00, 8'(8'hFE + 8'(k))}));
            tick();
        end

        // Back-pressure: two entries held, no further requests.
        id_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("bp_valid",  32'(id_valid), 1);
        chk("bp_pc",     32'(id_pc),    0);
        chk("bp_instr",  32'(id_instr), 32'h100);
        chk("bp_rom_en", 32'(rom_en),   0);
        id_ready = 1'b1;
        #1;
        chk("bp_rel_pc0",     32'(id_pc),    0);
        chk("bp_rel_rom_en",  32'(rom_en),   1);
        chk("bp_rel_rom_adr", 32'(rom_addr), 2);
        tick();
        chk("bp_rel_pc1", 32'(id_pc), 1);
        tick();
        chk("bp_rel_pc2", 32'(id_pc), 2);
        chk("bp_rel_v2",  32'(id_valid), 1);

        // Reset while words are queued and a ROM response is pending.
        id_ready = 1'b0;
        repeat (4) tick();
        id_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_id_valid", 32'(id_valid), 0);
        chk("mrst_rom_en",   32'(rom_en),   0);
        chk("mrst_rom_addr", 32'(rom_addr), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_c0_addr",  32'(rom_addr), 0);
        chk("mrst_c0_valid", 32'(id_valid), 0);
        tick();
        chk("mrst_c1_valid", 32'(id_valid), 0);
        tick();
        chk("mrst_c2_pc",    32'(id_pc),    0);
        chk("mrst_c2_instr", 32'(id_instr), 32'h100);
        tick();
        chk("mrst_c3_pc", 32'(id_pc), 1);

        // Alternating id_ready with a jump to 0x10 on an accept cycle.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            id_ready = (c % 2 == 0);
            jmp_ce   = (c == 6);
            jmp_addr = 8'h10;
            #1;
            if (id_valid && id_ready) got_q.push_back(id_pc);
            @(posedge clk);
            #1;
        end
        jmp_ce = 1'b0;
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
        chk("tog_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("tog_pc", 32'((i < got_q.size()) ? got_q[i] : 8'hxx), 32'(exp_q[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
